schematic: RTL and testbench
============================

// Module: schematic
// PURPOSE
//  Change-dispensing controller for the barcode checkout: I = amount inserted,
//  PG = price from the barcode reader. Computes change I-PG and pays it out as
//  10-unit (DEZ) then 2-unit (DOIS) coin pulses, then signals FIM.
//  Also exports FSM state, the change amounts and a 26-char ASCII status text.
// PARAMETERS
//  W         5   width of I, PG, moneyState and moneyToGive
//  COIN_HI   10  value of one DEZ pulse
//  COIN_LO   2   value of one DOIS pulse
//  MSG_CHARS 26  status text length in characters; message width = 8*MSG_CHARS
// PORTS
//  clock        in   1    single clock, rising edge
//  reset        in   1    synchronous, active-high
//  I            in   5    amount inserted (unsigned); 0 = none
//  PG           in   5    price to pay (unsigned); 0 = none
//  DEZ          out  1    one-cycle pulse: dispense one 10-unit coin
//  DOIS         out  1    one-cycle pulse: dispense one 2-unit coin
//  FIM          out  1    one-cycle pulse: transaction finished
//  moneyState   out  5    change still to be dispensed
//  moneyToGive  out  5    total change latched for the transaction (I-PG)
//  mainState    out  3    FSM state code
//  message      out  208  ASCII status, first char in [207:200], space padded
// BEHAVIOUR
//  All outputs registered. Reset: state IDLE, DEZ=DOIS=FIM=0,
//   moneyState=0, moneyToGive=0, message="READY".
//  States (mainState): 0 IDLE, 1 CALC, 2 GIVE, 3 DONE, 4 RELEASE, 5 ERROR.
//  IDLE: on an edge with I!=0 and PG!=0:
//   - I>=PG: moneyToGive<=I-PG, moneyState<=I-PG, go to CALC.
//   - I<PG: go to ERROR; moneyToGive and moneyState stay 0.
//  CALC: one cycle, then GIVE.
//  GIVE: one coin per cycle.
//   - moneyState>=10: DEZ=1, moneyState-=10.
//   - else if moneyState>=2: DOIS=1, moneyState-=2.
//   - else: go to DONE, no pulse.
//   - DEZ and DOIS are never high in the same cycle. Back-to-back pulses allowed.
//  DONE: FIM=1 for exactly one cycle, then RELEASE.
//   - An odd leftover of 1 stays in moneyState; it is not paid.
//  ERROR: FIM=1 for one cycle; no coins are paid. Then RELEASE.
//  RELEASE: hold until I==0 and PG==0, then go to IDLE.
//   - Inputs held for several cycles never start a second transaction.
//   - moneyToGive keeps its value until the next accepted transaction.
//  Latency: input sample edge -> first coin pulse = 2 cycles.
//   - Change 28: DEZ,DEZ,DOIS,DOIS,DOIS,DOIS; FIM 2 cycles after the last coin.
//  I/PG changes after the sample edge are ignored until RELEASE.
//  reset asserted mid-transaction aborts it: reset values on the next edge.
//  The subtraction is 5-bit unsigned; the I>=PG check prevents wrap-around.
// CONFIGURATION
//  MESSAGE_EN defined: message driven per state.
//   - IDLE "READY", CALC "CALCULATING CHANGE", GIVE "DISPENSING CHANGE",
//     DONE/RELEASE "THANK YOU", ERROR "INSUFFICIENT MONEY".
//  MESSAGE_EN undefined: message tied to 0; all other behaviour identical.
// TESTING
//  I=30,PG=28 held 3 cycles -> moneyToGive=2; one DOIS, no DEZ; FIM once;
//   moneyState=0.
//  I=30,PG=2 -> moneyToGive=28; DEZ x2 then DOIS x4 on consecutive cycles; FIM.
//  I=20,PG=20 -> moneyToGive=0; no coin pulses; FIM once.
//  I=10,PG=20 -> mainState=5; no DEZ/DOIS; FIM once; moneyToGive=0.
//  Inputs held nonzero 15 cycles after FIM -> stays in RELEASE.
//   - Inputs return to 0 -> IDLE; the next I=10,PG=4 gives DOIS x3.
//  reset=1 during GIVE for change 28 -> next cycle mainState=0, all outputs at
//   reset values; no further pulses.

Source files
------------

// File: rtl/schematic.sv
// Change-dispensing controller: latches I-PG, pays it out as COIN_HI then COIN_LO pulses, then pulses FIM.
// Optional feature: define MESSAGE_EN to drive the ASCII status text; otherwise message is tied to zero.
module schematic #(
   parameter int W         = 5,
   parameter int COIN_HI   = 10,
   parameter int COIN_LO   = 2,
   parameter int MSG_CHARS = 26
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [W-1:0]           I,
   input  logic [W-1:0]           PG,
   output logic                   DEZ,
   output logic                   DOIS,
   output logic                   FIM,
   output logic [W-1:0]           moneyState,
   output logic [W-1:0]           moneyToGive,
   output logic [2:0]             mainState,
   output logic [8*MSG_CHARS-1:0] message
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CALC    = 3'd1,
      GIVE    = 3'd2,
      DONE    = 3'd3,
      RELEASE = 3'd4,
      ERROR   = 3'd5
   } state_t;

   localparam logic [W-1:0] HI = W'(COIN_HI);
   localparam logic [W-1:0] LO = W'(COIN_LO);

   state_t         state_reg, state_next;
   logic           dez_reg, dez_next;
   logic           dois_reg, dois_next;
   logic           fim_reg, fim_next;
   logic [W-1:0]   ms_reg, ms_next;
   logic [W-1:0]   mtg_reg, mtg_next;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= IDLE;
         dez_reg   <= 1'b0;
         dois_reg  <= 1'b0;
         fim_reg   <= 1'b0;
         ms_reg    <= '0;
         mtg_reg   <= '0;
      end else begin
         state_reg <= state_next;
         dez_reg   <= dez_next;
         dois_reg  <= dois_next;
         fim_reg   <= fim_next;
         ms_reg    <= ms_next;
         mtg_reg   <= mtg_next;
      end
   end

   // Pulses default low every cycle, so each pulse lasts exactly one cycle.
   always_comb begin
      state_next = state_reg;
      dez_next   = 1'b0;
      dois_next  = 1'b0;
      fim_next   = 1'b0;
      ms_next    = ms_reg;
      mtg_next   = mtg_reg;
      case (state_reg)
         IDLE: begin
            if ((I != '0) && (PG != '0)) begin
               if (I >= PG) begin
                  mtg_next   = I - PG;
                  ms_next    = I - PG;
                  state_next = CALC;
               end else begin
                  state_next = ERROR;
               end
            end
         end
         CALC: state_next = GIVE;
         GIVE: begin
            if (ms_reg >= HI) begin
               dez_next = 1'b1;
               ms_next  = ms_reg - HI;
            end else if (ms_reg >= LO) begin
               dois_next = 1'b1;
               ms_next   = ms_reg - LO;
            end else begin
               state_next = DONE;
            end
         end
         DONE: begin
            fim_next   = 1'b1;
            state_next = RELEASE;
         end
         ERROR: begin
            fim_next   = 1'b1;
            state_next = RELEASE;
         end
         RELEASE: begin
            // Wait for the customer to clear both inputs so a held sale is not repeated.
            if ((I == '0) && (PG == '0))
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign DEZ         = dez_reg;
   assign DOIS        = dois_reg;
   assign FIM         = fim_reg;
   assign moneyState  = ms_reg;
   assign moneyToGive = mtg_reg;
   assign mainState   = state_reg;

`ifdef MESSAGE_EN
   localparam logic [8*MSG_CHARS-1:0] MSG_READY = {"READY", {(MSG_CHARS-5){8'h20}}};
   localparam logic [8*MSG_CHARS-1:0] MSG_CALC  = {"CALCULATING CHANGE", {(MSG_CHARS-18){8'h20}}};
   localparam logic [8*MSG_CHARS-1:0] MSG_GIVE  = {"DISPENSING CHANGE", {(MSG_CHARS-17){8'h20}}};
   localparam logic [8*MSG_CHARS-1:0] MSG_THANK = {"THANK YOU", {(MSG_CHARS-9){8'h20}}};
   localparam logic [8*MSG_CHARS-1:0] MSG_ERROR = {"INSUFFICIENT MONEY", {(MSG_CHARS-18){8'h20}}};

   logic [8*MSG_CHARS-1:0] message_reg, message_next;

   // Text follows the state being entered so it stays aligned with mainState.
   always_comb begin
      message_next = MSG_READY;
      case (state_next)
         IDLE:    message_next = MSG_READY;
         CALC:    message_next = MSG_CALC;
         GIVE:    message_next = MSG_GIVE;
         DONE:    message_next = MSG_THANK;
         RELEASE: message_next = MSG_THANK;
         ERROR:   message_next = MSG_ERROR;
         default: message_next = MSG_READY;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset)
         message_reg <= MSG_READY;
      else
         message_reg <= message_next;
   end

   assign message = message_reg;
`else
   assign message = '0;
`endif

endmodule

// File: tb/tb_schematic.sv
// Scoreboard bench for schematic: stimulus pushes expected coin/FIM events, a negedge monitor pops and checks them.
module tb_schematic;

   logic         clock = 1'b0;
   logic         reset;
   logic [4:0]   I, PG;
   logic         DEZ, DOIS, FIM;
   logic [4:0]   moneyState, moneyToGive;
   logic [2:0]   mainState;
   logic [207:0] message;

   schematic dut (
      .clock(clock), .reset(reset), .I(I), .PG(PG),
      .DEZ(DEZ), .DOIS(DOIS), .FIM(FIM),
      .moneyState(moneyState), .moneyToGive(moneyToGive),
      .mainState(mainState), .message(message)
   );

   always #5 clock = ~clock;

`ifdef MESSAGE_EN
   localparam logic [207:0] T_READY = {"READY", {21{8'h20}}};
   localparam logic [207:0] T_THANK = {"THANK YOU", {17{8'h20}}};
   localparam logic [207:0] T_ERROR = {"INSUFFICIENT MONEY", {8{8'h20}}};
`else
   localparam logic [207:0] T_READY = '0;
   localparam logic [207:0] T_THANK = '0;
   localparam logic [207:0] T_ERROR = '0;
`endif

   typedef struct {
      int         kind;   // 0 DEZ, 1 DOIS, 2 FIM
      int         cyc;
      logic [4:0] ms;
      logic [4:0] mtg;
   } ev_t;

   ev_t  sb[$];
   ev_t  e;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   fim_count = 0;
   int   exp_fim = 0;
   int   act_kind;
   logic [4:0] m_ms = 0, m_mtg = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [207:0] act, input logic [207:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end else begin
         $display("ok   %s = %0h (cycle %0d)", nm, act, cyc);
      end
   endtask

   task automatic push(input int kind, input int c);
      ev_t x;
      x.kind = kind; x.cyc = c; x.ms = m_ms; x.mtg = m_mtg;
      sb.push_back(x);
   endtask

   // Expected pulse train for a sale sampled on edge s.
   task automatic model_push(input logic [4:0] i, input logic [4:0] pg, input int s);
      int t;
      if (i >= pg) begin
         m_mtg = i - pg;
         m_ms  = i - pg;
         t = s + 2;
         while (m_ms >= 10) begin m_ms = m_ms - 10; push(0, t); t++; end
         while (m_ms >= 2)  begin m_ms = m_ms - 2;  push(1, t); t++; end
         push(2, t + 1);
      end else begin
         push(2, s + 1);
      end
      exp_fim++;
   endtask

   // Monitor: every pulse must match the head of the scoreboard.
   always @(negedge clock) begin
      if (DEZ === 1'b1 && DOIS === 1'b1) begin
         n_cmp++; n_bad++;
         $display("FAIL dez_dois_overlap: both high at cycle %0d, required at most one", cyc);
      end
      if (DEZ === 1'b1 || DOIS === 1'b1 || FIM === 1'b1) begin
         act_kind = (FIM === 1'b1) ? 2 : ((DEZ === 1'b1) ? 0 : 1);
         if (FIM === 1'b1) fim_count++;
         n_cmp++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_pulse: kind %0d at cycle %0d, required no pulse", act_kind, cyc);
         end else begin
            e = sb.pop_front();
            if (act_kind != e.kind || cyc != e.cyc || moneyState !== e.ms || moneyToGive !== e.mtg) begin
               n_bad++;
               $display("FAIL pulse: got kind %0d cyc %0d ms %0d mtg %0d, required kind %0d cyc %0d ms %0d mtg %0d",
                        act_kind, cyc, moneyState, moneyToGive, e.kind, e.cyc, e.ms, e.mtg);
            end else begin
               $display("ok   pulse kind %0d cyc %0d ms %0d mtg %0d", act_kind, cyc, moneyState, moneyToGive);
            end
         end
      end
   end

   // Issue a sale; hold < 0 leaves the inputs asserted.
   task automatic run(input logic [4:0] i, input logic [4:0] pg, input int hold,
                      input logic [2:0] exp_state, input logic [4:0] exp_mtg);
      int s;
      @(posedge clock); #2;
      I = i; PG = pg;
      s = cyc + 1;
      model_push(i, pg, s);
      @(negedge clock); @(negedge clock);
      chk("state_after_sample", {205'd0, mainState}, {205'd0, exp_state});
      chk("money_to_give", {203'd0, moneyToGive}, {203'd0, exp_mtg});
      if (hold >= 0) begin
         repeat (hold) @(posedge clock);
         #2; I = 0; PG = 0;
      end
   endtask

   task automatic wait_fim;
      int k;
      k = 0;
      while (fim_count < exp_fim && k < 80) begin @(posedge clock); #1; k++; end
      n_cmp++;
      if (fim_count < exp_fim) begin
         n_bad++;
         $display("FAIL fim_timeout: got %0d FIM pulses, required %0d", fim_count, exp_fim);
      end
   endtask

   initial begin
      int s;
      reset = 1'b1; I = 0; PG = 0;
      repeat (3) @(posedge clock);
      #2; reset = 1'b0;
      chk("reset_state", {205'd0, mainState}, 208'd0);
      chk("reset_pulses", {205'd0, DEZ, DOIS, FIM}, 208'd0);
      chk("reset_ms", {203'd0, moneyState}, 208'd0);
      chk("reset_mtg", {203'd0, moneyToGive}, 208'd0);
      chk("reset_msg", message, T_READY);

      run(5'd30, 5'd28, 2, 3'd1, 5'd2);
      wait_fim();
      repeat (2) @(posedge clock); #2;
      chk("idle_after_t1", {205'd0, mainState}, 208'd0);

      run(5'd30, 5'd2, 1, 3'd1, 5'd28);
      wait_fim();
      repeat (2) @(posedge clock);

      run(5'd20, 5'd20, 1, 3'd1, 5'd0);
      wait_fim();
      repeat (2) @(posedge clock);

      run(5'd10, 5'd20, -1, 3'd5, 5'd0);
      chk("error_msg", message, T_ERROR);
      wait_fim();
      repeat (15) @(posedge clock); #2;
      chk("held_release_state", {205'd0, mainState}, 208'd4);
      chk("release_msg", message, T_THANK);
      I = 0; PG = 0;
      repeat (2) @(posedge clock); #2;
      chk("idle_after_release", {205'd0, mainState}, 208'd0);
      chk("idle_msg", message, T_READY);

      run(5'd10, 5'd4, 1, 3'd1, 5'd6);
      wait_fim();
      repeat (2) @(posedge clock);

      // Abort change 28 after its second DEZ pulse.
      @(posedge clock); #2;
      I = 30; PG = 2;
      s = cyc + 1;
      model_push(5'd30, 5'd2, s);
      while (cyc < s + 3) begin @(posedge clock); #1; end
      #1; reset = 1'b1; I = 0; PG = 0;
      @(posedge clock); #1;
      sb.delete();
      exp_fim = fim_count;
      m_ms = 0; m_mtg = 0;
      chk("abort_state", {205'd0, mainState}, 208'd0);
      chk("abort_pulses", {205'd0, DEZ, DOIS, FIM}, 208'd0);
      chk("abort_ms", {203'd0, moneyState}, 208'd0);
      chk("abort_mtg", {203'd0, moneyToGive}, 208'd0);
      chk("abort_msg", message, T_READY);
      #1; reset = 1'b0;
      repeat (12) @(posedge clock); #2;
      chk("abort_quiet_state", {205'd0, mainState}, 208'd0);

      chk("scoreboard_drained", 208'(sb.size()), 208'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
